// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the shared single-port program/data RAM.
// Round-robin between core and UART loader, with a loader bus-lock and a core-starvation timeout.
module ram_arbiter #(
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOCK_MAX = 64
) (
  input  logic              clk_i,
  input  logic              rst_n,
  // Core port
  input  logic              c_req_i,
  input  logic              c_we_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic [DATA_W-1:0] c_wdata_i,
  output logic              c_gnt_o,
  output logic              c_rvalid_o,
  output logic [DATA_W-1:0] c_rdata_o,
  // Loader port
  input  logic              l_req_i,
  input  logic              l_we_i,
  input  logic [ADDR_W-1:0] l_addr_i,
  input  logic [DATA_W-1:0] l_wdata_i,
  input  logic              l_lock_i,
  output logic              l_gnt_o,
  output logic              l_rvalid_o,
  output logic [DATA_W-1:0] l_rdata_o,
  // RAM macro
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  // Status
  output logic              lock_to_o,
  output logic [1:0]        arb_state_o
);

  typedef enum logic [1:0] {
    StArb       = 2'd0,
    StLocked    = 2'd1,
    StForceCore = 2'd2
  } state_e;

  localparam logic [15:0] LockLast = 16'(LOCK_MAX - 1);

  state_e      state_q;
  logic        last_q;      // 1: loader won the most recent transfer
  logic [15:0] lock_cnt_q;
  logic        c_rvalid_q;
  logic        l_rvalid_q;
  logic        lock_to_q;

  logic c_gnt;
  logic l_gnt;
  logic c_xfer;
  logic l_xfer;

  // Grants are held low during reset even though the state already reads StArb.
  always_comb begin
    c_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst_n) begin
      case (state_q)
        StArb: begin
          c_gnt = c_req_i && (!l_req_i || last_q);
          l_gnt = l_req_i && (!c_req_i || !last_q);
        end
        StLocked:    l_gnt = l_req_i;
        StForceCore: c_gnt = c_req_i;
        default: ;
      endcase
    end
  end

  assign c_xfer = c_req_i && c_gnt;
  assign l_xfer = l_req_i && l_gnt;

  assign ram_addr_o  = l_gnt ? l_addr_i  : c_addr_i;
  assign ram_wdata_o = l_gnt ? l_wdata_i : c_wdata_i;
  assign ram_we_o    = (c_xfer && c_we_i) || (l_xfer && l_we_i);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StArb;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      c_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      lock_to_q  <= 1'b0;
    end else begin
      c_rvalid_q <= c_xfer && !c_we_i;
      l_rvalid_q <= l_xfer && !l_we_i;
      lock_to_q  <= 1'b0;
      if (l_xfer) begin
        last_q <= 1'b1;
      end else if (c_xfer) begin
        last_q <= 1'b0;
      end
      case (state_q)
        StArb: begin
          if (l_xfer && l_lock_i) begin
            state_q    <= StLocked;
            lock_cnt_q <= '0;
          end
        end
        StLocked: begin
          if (c_req_i && (lock_cnt_q != 16'hFFFF)) begin
            lock_cnt_q <= lock_cnt_q + 16'd1;
          end
          // Lock release wins over a timeout on the same edge.
          if (!l_lock_i) begin
            state_q <= StArb;
            last_q  <= 1'b1;
          end else if (c_req_i && (lock_cnt_q == LockLast)) begin
            state_q   <= StForceCore;
            lock_to_q <= 1'b1;
          end
        end
        StForceCore: begin
          if (c_xfer || !c_req_i) begin
            if (l_lock_i) begin
              state_q    <= StLocked;
              lock_cnt_q <= '0;
            end else begin
              state_q <= StArb;
              last_q  <= 1'b0;
            end
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

  assign c_gnt_o     = c_gnt;
  assign l_gnt_o     = l_gnt;
  assign c_rvalid_o  = c_rvalid_q;
  assign l_rvalid_o  = l_rvalid_q;
  assign c_rdata_o   = ram_rdata_i;
  assign l_rdata_o   = ram_rdata_i;
  assign lock_to_o   = lock_to_q;
  assign arb_state_o = state_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 8K x 32 program/data RAM between two requesters: the CORE memory port and the UART loader, which writes program images and reads back memory.
- Round-robin arbitration with a loader bus-lock for burst uploads.
- A lock timeout guarantees the core forward progress while the loader holds the lock.
- Sits between the requesters and the RAM macro, which has synchronous read with 1-cycle latency.

Parameters:
- ADDR_W, 13, RAM word-address width.
- DATA_W, 32, RAM data width.
- LOCK_MAX, 64, core-waiting cycles tolerated under loader lock before forcing a core grant; legal range 2..65535.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- c_req  in  1  core access request.
- c_we  in  1  core write enable (0 = read).
- c_addr  in  ADDR_W  core word address.
- c_wdata  in  DATA_W  core write data.
- c_gnt  out  1  core grant; transfer occurs on an edge where c_req && c_gnt.
- c_rvalid  out  1  core read data valid.
- c_rdata  out  DATA_W  core read data.
- l_req, l_we, l_addr, l_wdata  in  1/1/ADDR_W/DATA_W  loader request, same meaning as the core signals.
- l_lock  in  1  loader requests bus lock; sampled with each loader transfer and every cycle in LOCKED.
- l_gnt, l_rvalid, l_rdata  out  1/1/DATA_W  loader grant, read valid, read data.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write strobe.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after the read address is presented.
- lock_to  out  1  1-cycle pulse when the lock timeout fires.
- arb_state  out  2  current FSM state, for debug.

Behaviour:

Handshake:
- Requester holds req/we/addr/wdata stable until it sees the grant.
- A transfer completes at the rising edge where req && gnt.
- gnt is combinational from the registered state and the current req.
- At most one grant is high per cycle.

RAM side:
- ram_addr and ram_wdata are a combinational mux of the winner; they follow the core when there is no winner.
- ram_we = winner_req && winner_we.
- ram_we is never high without a grant.

Read return:
- c_rvalid / l_rvalid are registered: high for exactly one cycle following a read transfer by that requester.
- c_rdata = l_rdata = ram_rdata, passed straight through; the requester qualifies it with its own rvalid.
- Write transfers produce no rvalid.
- Back-to-back reads by one requester yield rvalid on consecutive cycles.

Registers:
- state: ARB=0, LOCKED=1, FORCE_CORE=2.
- last: 1 means the loader won last.
- lock_cnt: 16 bits.
- rvalid flags.

Reset (async, rst_n=0):
- state=ARB, last=1 (core wins the first tie), lock_cnt=0.
- c_rvalid=l_rvalid=0, lock_to=0.
- Grants evaluate to 0 while in reset.
- A reset mid-read drops the pending rvalid.

ARB state:
- Single requester is granted.
- Both requesting: grant the one not equal to last.
- last updates on each transfer.
- Loader transfer with l_lock=1 -> LOCKED, lock_cnt<=0.

LOCKED state:
- Only the loader may be granted; c_gnt=0.
- lock_cnt increments on each cycle with c_req=1 and saturates.
- l_lock=0 at an edge -> ARB, with last=1.
- When lock_cnt==LOCK_MAX-1 and c_req=1 and l_lock=1 at an edge -> FORCE_CORE, lock_to=1 for the next cycle.
- l_lock release takes precedence over timeout on the same edge.

FORCE_CORE state:
- Only the core may be granted; l_gnt=0.
- A core transfer, or c_req=0, at an edge leaves the state: to LOCKED (lock_cnt<=0) if l_lock=1, else to ARB (last=0).

Other rules:
- l_lock is ignored on core transfers and outside loader grants.
- arb_state equals the encoded state.

Test Plan:
1. Reset, then core read addr 0x0010 alone, with the RAM model preloaded so 0x0010=0xDEADBEEF -> c_gnt=1 same cycle, ram_addr=0x0010, c_rvalid=1 next cycle with c_rdata=0xDEADBEEF, l_rvalid=0.
2. Both requesters hold reads continuously from reset -> grants alternate core, loader, core, loader; never both high; each rvalid lags its grant by exactly 1 cycle.
3. Loader writes 0x0000..0x0007 with l_lock=1 while core requests -> ram_we high 8 cycles with loader data, c_gnt=0 throughout; after l_lock drops, core is granted next cycle, lock_to never pulses.
4. LOCK_MAX=4, loader locked streaming writes, core requesting -> after 4 core-waiting cycles lock_to pulses once, next cycle c_gnt=1 for exactly one transfer, then state returns to LOCKED (arb_state=1) and the counter restarts.
5. Assert rst_n=0 in the cycle after a loader read transfer -> l_rvalid stays 0, arb_state=0, and the first post-reset tie goes to the core.
6. FORCE_CORE entered, then core drops c_req before being granted while l_lock=0 -> next state ARB, loader granted immediately, no ram_we glitch.
